spread_frame_sched: RTL and testbench
=====================================

// Module: spread_frame_sched
// PURPOSE
//  Frame scheduler in front of the DSSS bit spreader. On a start command it emits preamble, 8-bit
//  length header, then LEN payload bytes (MSB first) as a serial bit stream. Each bit is paced
//  to the spreader's bit-request pulse, so the spreader never idles mid-frame.
//  Sits between the byte source (MAC/FIFO) and the spreader.
// PARAMETERS
//  PREAMBLE_BITS  16        preamble length in bits (1..32)
//  PREAMBLE_PAT   32'hA5F0  preamble pattern; bits [PREAMBLE_BITS-1:0] sent MSB first
//  MAX_LEN        255       maximum payload bytes; i_len above it is rejected
// PORTS
//  i_clk         in   1  clock
//  i_reset       in   1  reset, asynchronous, active-high
//  i_start       in   1  frame request pulse; sampled only in IDLE
//  i_len         in   8  payload byte count, sampled with i_start; 0 = header-only frame
//  o_busy        out  1  high from accepted start until frame end
//  o_done        out  1  1-cycle pulse when frame completes normally
//  o_err         out  1  1-cycle pulse: rejected start (len>MAX_LEN) or payload underrun
//  i_byte        in   8  payload byte
//  i_byte_valid  in   1  payload byte available
//  o_byte_ready  out  1  byte consumed this cycle (valid&ready transfer)
//  i_spr_ready   in   1  spreader bit-request pulse: next bit is sampled one cycle later
//  i_spr_active  in   1  spreader currently spreading a bit (its output valid)
//  o_spr_data    out  1  bit to spreader
//  o_spr_valid   out  1  bit valid to spreader
// BEHAVIOUR
//  Reset: o_busy, o_done, o_err, o_byte_ready, o_spr_data, o_spr_valid = 0; FSM = IDLE; counters 0.
//  Reset mid-frame aborts immediately; o_done is not pulsed.
//  FSM: IDLE -> PRE -> HDR -> PAY -> FLUSH -> IDLE.
//   IDLE:  i_start & i_len<=MAX_LEN -> PRE; o_busy=1 next cycle.
//          i_start & i_len>MAX_LEN -> o_err pulse; stay in IDLE.
//   PRE:   PREAMBLE_BITS bits. HDR: 8 bits of length. PAY: LEN*8 bits.
//   After the last bit is issued -> FLUSH. HDR with LEN=0 goes straight to FLUSH.
//  Bit issue:
//   - First bit: driven with o_spr_valid=1 in the cycle after start acceptance. Held until a
//     cycle with i_spr_active=0, which counts as consumed at that edge.
//   - Next bits: on each edge with i_spr_ready=1, the next bit is registered onto o_spr_data
//     with o_spr_valid=1. It is consumed at the following edge.
//   - o_spr_data is stable from registration until consumption.
//  Byte fetch: the shift register loads a new byte when the last bit of the previous byte is
//   consumed. o_byte_ready is high for exactly that cycle, combinational with i_byte_valid.
//   HDR bits come from the latched length; no byte fetch is made for the header.
//  Underrun: i_byte_valid=0 when a payload byte is needed ->
//   o_err pulse, o_spr_valid=0, go to FLUSH.
//  FLUSH: o_spr_valid=0. Wait until i_spr_active=0 (last bit fully spread).
//   Then o_busy=0, o_done pulse (not on underrun) -> IDLE.
//  i_start outside IDLE is ignored, with no error.
//  i_spr_ready while o_spr_valid=0 is ignored.
//  Counters:
//   - bit counter: 3 bits, wraps at 8.
//   - byte counter: 8 bits, compared to the latched LEN, no wrap.
//   - preamble counter: $clog2(PREAMBLE_BITS+1) bits.
// STRUCTURE
//  Package spread_pkg: state enum (IDLE, PRE, HDR, PAY, FLUSH) and the LEN_W=8 constant.
//  Sub-module spread_bit_shifter (8-bit MSB-first shifter with load/shift/empty flag); used for
//   HDR and PAY. The preamble is shifted from a PREAMBLE_BITS register in the top.
// TESTING
//  Bench model: the spreader pulses i_spr_ready every 24 cycles while active, and holds
//   i_spr_active accordingly.
//  1. PREAMBLE_BITS=16, pattern A5F0, i_len=2, bytes 3C,81 ->
//     serial 1010010111110000_00000010_00111100_10000001. Then o_done x1, o_busy low.
//  2. i_len=0 -> preamble + 00000000. o_byte_ready never asserts; o_done pulses.
//  3. i_len=2, i_byte_valid dropped before the 2nd byte ->
//     o_err pulse, no o_done, o_spr_valid=0, back to IDLE after spreader drains.
//  4. i_start with i_len=8'hFF and MAX_LEN=200 -> o_err 1 cycle, o_busy stays 0.
//  5. Reset asserted during PAY byte 1 -> all outputs 0 next cycle.
//     Fresh i_start then sends a full correct frame.
//  6. i_start re-pulsed mid-frame and i_spr_ready glitch while idle ->
//     bitstream unchanged, no extra bits.

Source files
------------

// File: rtl/spread_pkg.sv
// Shared types and constants for the DSSS frame scheduler.
package spread_pkg;

  localparam int unsigned LEN_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    PAY,
    FLUSH
  } state_t;

endpackage

// File: rtl/spread_bit_shifter.sv
// 8-bit MSB-first shift register feeding header and payload bits to the spreader.
module spread_bit_shifter
  import spread_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [LEN_W-1:0] load_data,
  output logic             bit_out,
  output logic             empty
);

  logic [LEN_W-1:0] sr;
  logic [2:0]       bit_cnt;

  // Load and shift in the same cycle hands out the new MSB directly.
  assign bit_out = load ? load_data[LEN_W-1] : sr[LEN_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
      empty   <= 1'b1;
    end else if (load) begin
      sr      <= shift ? (load_data << 1) : load_data;
      bit_cnt <= shift ? 3'd1 : 3'd0;
      empty   <= 1'b0;
    end else if (shift && !empty) begin
      sr      <= sr << 1;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) empty <= 1'b1;
    end
  end

endmodule

// File: rtl/spread_frame_sched.sv
// Frame scheduler: preamble, length header and payload bytes serialised MSB first,
// one bit per spreader request.
module spread_frame_sched
  import spread_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [31:0] PREAMBLE_PAT  = 32'hA5F0,
  parameter int unsigned MAX_LEN       = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  input  logic [LEN_W-1:0] i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  input  logic             i_spr_ready,
  input  logic             i_spr_active,
  output logic             o_spr_data,
  output logic             o_spr_valid
);

  localparam int unsigned     PC_W    = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PC_W-1:0] PRE_END = PC_W'(PREAMBLE_BITS);
  localparam logic [LEN_W:0]  MAX_L   = (LEN_W + 1)'(MAX_LEN);

  state_t state, state_nx;

  logic [PREAMBLE_BITS-1:0] pre_sr;
  logic [PC_W-1:0]          pre_cnt;
  logic [LEN_W-1:0]         len;
  logic [LEN_W-1:0]         byte_cnt;
  logic                     first_pend;
  logic                     cons_pend;
  logic                     underrun_seen;

  logic accept, reject, consume, seg_end, pre_src;
  logic hdr_load, byte_load, go_flush, underrun, finish, issue;
  logic sh_load, sh_shift, sh_bit, sh_empty;

  spread_bit_shifter u_shifter (
    .clk       (i_clk),
    .reset     (i_reset),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (hdr_load ? len : i_byte),
    .bit_out   (sh_bit),
    .empty     (sh_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // The bit on o_spr_data is consumed either when the idle spreader samples the first
  // bit (i_spr_active low) or one edge after a request registered it. Segment
  // boundaries and byte fetches are decided at that consumption edge.
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    reject       = 1'b0;
    hdr_load     = 1'b0;
    byte_load    = 1'b0;
    go_flush     = 1'b0;
    underrun     = 1'b0;
    finish       = 1'b0;
    o_byte_ready = 1'b0;
    consume      = 1'b0;
    if (state inside {PRE, HDR, PAY})
      consume = first_pend ? !i_spr_active : cons_pend;
    pre_src = (state == PRE) && (pre_cnt != PRE_END);
    seg_end = consume && ((state == PRE) ? (pre_cnt == PRE_END) : sh_empty);

    unique case (state)
      IDLE: begin
        if (i_start) begin
          if ({1'b0, i_len} > MAX_L) begin
            reject = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = PRE;
          end
        end
      end
      PRE: begin
        if (seg_end) begin
          hdr_load = 1'b1;
          state_nx = HDR;
        end
      end
      HDR, PAY: begin
        if (seg_end) begin
          if (byte_cnt == len) begin
            go_flush = 1'b1;
          end else if (i_byte_valid) begin
            byte_load    = 1'b1;
            o_byte_ready = 1'b1;
            state_nx     = PAY;
          end else begin
            underrun = 1'b1;
            go_flush = 1'b1;
          end
          if (go_flush) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (!i_spr_active) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    sh_load  = hdr_load || byte_load;
    issue    = i_spr_ready && o_spr_valid && !first_pend && !go_flush &&
               (pre_src || sh_load || (state != PRE && !sh_empty));
    sh_shift = issue && !pre_src;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_spr_data    <= 1'b0;
      o_spr_valid   <= 1'b0;
      pre_sr        <= '0;
      pre_cnt       <= '0;
      len           <= '0;
      byte_cnt      <= '0;
      first_pend    <= 1'b0;
      cons_pend     <= 1'b0;
      underrun_seen <= 1'b0;
    end else begin
      o_done    <= finish && !underrun_seen;
      o_err     <= reject || underrun;
      cons_pend <= issue;
      if (accept) begin
        len           <= i_len;
        byte_cnt      <= '0;
        pre_cnt       <= PC_W'(1);
        pre_sr        <= PREAMBLE_PAT[PREAMBLE_BITS-1:0] << 1;
        o_spr_data    <= PREAMBLE_PAT[PREAMBLE_BITS-1];
        o_spr_valid   <= 1'b1;
        o_busy        <= 1'b1;
        first_pend    <= 1'b1;
        underrun_seen <= 1'b0;
      end else begin
        if (consume && first_pend) first_pend <= 1'b0;
        if (byte_load) byte_cnt <= byte_cnt + 1'b1;
        if (underrun) underrun_seen <= 1'b1;
        if (go_flush) o_spr_valid <= 1'b0;
        if (finish) o_busy <= 1'b0;
        if (issue) begin
          if (pre_src) begin
            o_spr_data <= pre_sr[PREAMBLE_BITS-1];
            pre_sr     <= pre_sr << 1;
            pre_cnt    <= pre_cnt + 1'b1;
          end else begin
            o_spr_data <= sh_bit;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spread_frame_sched.sv
// Scoreboard bench: a spreader model consumes bits, a monitor compares them with frames
// built from the preamble/header/payload rules.
module tb_spread_frame_sched;

  localparam int unsigned P       = 16;
  localparam logic [31:0] PAT     = 32'hA5F0;
  localparam int unsigned MAXL    = 200;
  localparam int unsigned BIT_CYC = 24;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_len = '0;
  logic       o_busy, o_done, o_err;
  logic [7:0] i_byte = '0;
  logic       i_byte_valid = 1'b0;
  logic       o_byte_ready;
  logic       i_spr_ready = 1'b0;
  logic       i_spr_active = 1'b0;
  logic       o_spr_data, o_spr_valid;

  spread_frame_sched #(
    .PREAMBLE_BITS (P),
    .PREAMBLE_PAT  (PAT),
    .MAX_LEN       (MAXL)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .i_spr_ready  (i_spr_ready),
    .i_spr_active (i_spr_active),
    .o_spr_data   (o_spr_data),
    .o_spr_valid  (o_spr_valid)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_err;
    int unsigned nbytes;
  } ev_t;

  bit          exp_bits[$];
  ev_t         ev_q[$];
  logic [7:0]  src_q[$];
  logic [7:0]  pay[$];
  ev_t         ev;
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned ev_seen = 0, exp_ev = 0, bytes_seen = 0, ph = 0;
  bit          sp_act = 0, sp_take = 0, sp_bit = 0, glitch_req = 0, byte_pop = 0;
  bit          prev_done = 0, prev_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Spreader: samples a bit, spreads it BIT_CYC cycles, requests the next bit one cycle
  // before sampling it; goes idle when no bit is offered.
  initial forever begin
    @(negedge i_clk);
    i_spr_ready = 1'b0;
    sp_take     = 1'b0;
    if (i_reset) begin
      sp_act       = 1'b0;
      i_spr_active = 1'b0;
      ph           = 0;
    end else if (!sp_act) begin
      i_spr_active = 1'b0;
      i_spr_ready  = glitch_req;
      if (o_spr_valid) begin
        sp_take = 1'b1;
        sp_bit  = o_spr_data;
        sp_act  = 1'b1;
        ph      = 0;
      end
    end else begin
      i_spr_active = 1'b1;
      ph++;
      if (ph == BIT_CYC - 1) begin
        i_spr_ready = 1'b1;
      end else if (ph == BIT_CYC) begin
        if (o_spr_valid) begin
          sp_take = 1'b1;
          sp_bit  = o_spr_data;
          ph      = 0;
        end else begin
          sp_act       = 1'b0;
          i_spr_active = 1'b0;
        end
      end
    end
  end

  // Byte source: presents the head of src_q while it holds bytes.
  initial forever begin
    @(negedge i_clk);
    if (byte_pop && src_q.size() > 0) void'(src_q.pop_front());
    byte_pop     = 1'b0;
    i_byte_valid = (src_q.size() > 0);
    i_byte       = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Monitor: compares consumed bits and frame-end pulses against the scoreboard.
  initial forever begin
    @(negedge i_clk);
    #4;
    if (i_reset) begin
      prev_done  = 0;
      prev_err   = 0;
      bytes_seen = 0;
    end else begin
      if (sp_take) begin
        chk("bit_expected", (exp_bits.size() > 0), 1);
        if (exp_bits.size() > 0) chk("bit", sp_bit, exp_bits.pop_front());
      end
      if (o_byte_ready) begin
        byte_pop = 1'b1;
        bytes_seen++;
      end
      if (o_done || o_err) begin
        chk("end_pulse_expected", (ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          ev = ev_q.pop_front();
          chk("end_err", o_err, ev.is_err);
          chk("end_done", o_done, !ev.is_err);
          chk("bytes_fetched", bytes_seen, ev.nbytes);
          chk("bits_left", exp_bits.size(), 0);
          if (o_done) chk("busy_at_done", o_busy, 0);
        end
        chk("pulse_width", {prev_done & o_done, prev_err & o_err}, 0);
        bytes_seen = 0;
        ev_seen++;
      end
      prev_done = o_done;
      prev_err  = o_err;
    end
  end

  task automatic pulse_start(input logic [7:0] len);
    @(negedge i_clk);
    i_start = 1'b1;
    i_len   = len;
    @(negedge i_clk);
    i_start = 1'b0;
    i_len   = $urandom_range(255, 0);
  endtask

  // Builds the expected stream for a frame whose source holds 'avail' (<= len) bytes of pay.
  task automatic send_frame(input logic [7:0] len, input int unsigned avail);
    logic [31:0] pat;
    logic [7:0]  b;
    int unsigned sent;
    pat  = PAT;
    sent = (avail < len) ? avail : len;
    for (int i = P - 1; i >= 0; i--) exp_bits.push_back(pat[i]);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(len[i]);
    for (int k = 0; k < int'(sent); k++) begin
      b = pay[k];
      for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
    end
    ev_q.push_back('{is_err: (avail < len), nbytes: sent});
    exp_ev++;
    for (int k = 0; k < int'(sent); k++) src_q.push_back(pay[k]);
    pulse_start(len);
    #1;
    chk("busy_after_accept", o_busy, 1);
    chk("valid_after_accept", o_spr_valid, 1);
  endtask

  task automatic wait_end(input int unsigned len);
    int unsigned n = 0;
    int unsigned budget;
    budget = (P + 8 + 8 * len + 3) * BIT_CYC + 100;
    while (ev_seen < exp_ev && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("frame_end_seen", ev_seen, exp_ev);
    n = 0;
    while (o_busy && n < 4 * BIT_CYC) begin
      @(negedge i_clk);
      n++;
    end
    chk("idle_after_frame", o_busy, 0);
  endtask

  task automatic fill_pay(input int unsigned n);
    pay.delete();
    for (int k = 0; k < int'(n); k++) pay.push_back(8'($urandom));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_byte_ready"}, o_byte_ready, 0);
    chk({tag, "_spr_data"}, o_spr_data, 0);
    chk({tag, "_spr_valid"}, o_spr_valid, 0);
  endtask

  initial begin
    int unsigned n;
    int unsigned len, avail;
    repeat (3) @(negedge i_clk);
    #1;
    check_outputs_zero("reset");
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Known frame: 3C, 81
    pay.delete();
    pay.push_back(8'h3C);
    pay.push_back(8'h81);
    send_frame(8'd2, 2);
    wait_end(2);

    // Header-only frame
    pay.delete();
    send_frame(8'd0, 0);
    wait_end(0);

    // Underrun before the second byte
    pay.delete();
    pay.push_back(8'h3C);
    send_frame(8'd2, 1);
    n = 0;
    while (ev_seen < exp_ev && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    #4;
    chk("underrun_valid_low", o_spr_valid, 0);
    chk("underrun_still_draining", o_busy, 1);
    wait_end(2);

    // Rejected lengths just above and well above MAX_LEN
    for (int r = 0; r < 2; r++) begin
      ev_q.push_back('{is_err: 1'b1, nbytes: 0});
      exp_ev++;
      pulse_start((r == 0) ? 8'd201 : 8'hFF);
      for (int c = 0; c < 4; c++) begin
        #1;
        chk("reject_busy_low", o_busy, 0);
        @(negedge i_clk);
      end
      chk("reject_seen", ev_seen, exp_ev);
    end

    // Largest legal length is accepted; an empty source ends it at the header
    pay.delete();
    send_frame(8'd200, 0);
    wait_end(0);

    // Reset during the first payload byte
    fill_pay(3);
    send_frame(8'd3, 3);
    n = 0;
    while (bytes_seen < 1 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    chk("reached_payload", bytes_seen, 1);
    repeat (30) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_bits.delete();
    ev_q.delete();
    src_q.delete();
    exp_ev = ev_seen;
    byte_pop = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    fill_pay(2);
    send_frame(8'd2, 2);
    wait_end(2);

    // Start re-pulsed mid-frame, then a request glitch while idle
    fill_pay(2);
    send_frame(8'd2, 2);
    repeat (200) @(negedge i_clk);
    pulse_start(8'hFF);
    repeat (300) @(negedge i_clk);
    pulse_start(8'd1);
    wait_end(2);
    @(negedge i_clk);
    glitch_req = 1'b1;
    repeat (2) @(negedge i_clk);
    glitch_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("glitch_valid_low", o_spr_valid, 0);
      chk("glitch_busy_low", o_busy, 0);
      @(negedge i_clk);
    end
    fill_pay(1);
    send_frame(8'd1, 1);
    wait_end(1);

    // Randomised frames, some with a short byte source
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(5, 0);
      avail = ($urandom_range(3, 0) == 0) ? $urandom_range(len, 0) : len;
      fill_pay(avail);
      send_frame(8'(len), avail);
      wait_end(len);
      repeat ($urandom_range(5, 1)) @(negedge i_clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
